// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Provides the forwarding select encoding and the load-use counter width function.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  // Counter must hold LOAD_LAT-1; never narrower than one bit.
  function automatic int LU_CNT_W(input int load_lat);
    int w;
    w = $clog2(load_lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: M-stage result wins over W-stage, register 0 never forwards.
// Purely combinational.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             reg_write_enM,
  input  logic [REG_W-1:0] reg_writeM,
  input  logic             reg_write_enW,
  input  logic [REG_W-1:0] reg_writeW,
  output fwd_sel_t         sel
);

  logic src_nz;
  logic hit_m;
  logic hit_w;

  assign src_nz = (src != '0);
  assign hit_m  = src_nz & reg_write_enM & (src == reg_writeM);
  assign hit_w  = src_nz & reg_write_enW & (src == reg_writeW);

  always_comb begin
    sel = FWD_NONE;
    if (hit_m) begin
      sel = FWD_MEM;
    end else if (hit_w) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, multi-cycle load-use interlock, stall merge, flushes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int N_STALL  = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef HAZARD_PERF_CNT_EN
  input  logic               perf_clr,
  output logic [31:0]        perf_lu_cycles,
  output logic [31:0]        perf_long_cycles,
  output logic [31:0]        perf_pred_flushes,
`endif
  input  logic [N_STALL-1:0] long_stall_req,
  input  logic               loadE,
  input  logic               flush_pred_failedM,
  input  logic               flush_exceptionM,
  input  logic [REG_W-1:0]   rsD,
  input  logic [REG_W-1:0]   rtD,
  input  logic [REG_W-1:0]   rsE,
  input  logic [REG_W-1:0]   rtE,
  input  logic               reg_write_enE,
  input  logic               reg_write_enM,
  input  logic               reg_write_enW,
  input  logic [REG_W-1:0]   reg_writeE,
  input  logic [REG_W-1:0]   reg_writeM,
  input  logic [REG_W-1:0]   reg_writeW,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               stallW,
  output logic               flushF,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic               flushW,
  output logic [1:0]         forward_aE,
  output logic [1:0]         forward_bE,
  output logic               lu_busy
);

  localparam int               CNT_W   = LU_CNT_W(LOAD_LAT);
  localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LOAD_LAT - 1);

  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic             long_stall;
  logic             pred_eff;
  logic             flush_any;
  logic             hit_rs;
  logic             hit_rt;
  logic             detect;
  logic             pend;
  logic             pend_next;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] lu_cnt_next;

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src           (rsE),
    .reg_write_enM (reg_write_enM),
    .reg_writeM    (reg_writeM),
    .reg_write_enW (reg_write_enW),
    .reg_writeW    (reg_writeW),
    .sel           (fwd_a)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src           (rtE),
    .reg_write_enM (reg_write_enM),
    .reg_writeM    (reg_writeM),
    .reg_write_enW (reg_write_enW),
    .reg_writeW    (reg_writeW),
    .sel           (fwd_b)
  );

  assign forward_aE = fwd_a;
  assign forward_bE = fwd_b;

  // A mispredict seen under a global stall is parked in pend and released on the first free cycle.
  assign long_stall = |long_stall_req;
  assign pred_eff   = (flush_pred_failedM | pend) & ~long_stall;
  assign flush_any  = flush_exceptionM | pred_eff;

  assign hit_rs  = (rsD != '0) & (rsD == reg_writeE);
  assign hit_rt  = (rtD != '0) & (rtD == reg_writeE);
  assign detect  = loadE & reg_write_enE & (hit_rs | hit_rt) & ~flush_any;
  assign lu_busy = detect | ((lu_cnt != '0) & ~flush_any);

  always_comb begin
    lu_cnt_next = lu_cnt;
    if (flush_any) begin
      lu_cnt_next = '0;
    end else if (!long_stall) begin
      if (lu_cnt != '0) begin
        lu_cnt_next = lu_cnt - CNT_W'(1);
      end else if (detect) begin
        lu_cnt_next = LU_LOAD;
      end
    end
  end

  always_comb begin
    pend_next = pend;
    if (flush_exceptionM || !long_stall) begin
      pend_next = 1'b0;
    end else if (flush_pred_failedM) begin
      pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt <= '0;
      pend   <= 1'b0;
    end else begin
      lu_cnt <= lu_cnt_next;
      pend   <= pend_next;
    end
  end

  assign stallF = long_stall | lu_busy;
  assign stallD = long_stall | lu_busy;
  assign stallE = long_stall;
  assign stallM = long_stall;
  assign stallW = long_stall;

  // The bubble into E is only inserted when E itself is free to advance.
  assign flushF = 1'b0;
  assign flushD = flush_exceptionM;
  assign flushE = flush_exceptionM | pred_eff | (lu_busy & ~long_stall);
  assign flushM = flush_exceptionM;
  assign flushW = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_cycles    <= '0;
      perf_long_cycles  <= '0;
      perf_pred_flushes <= '0;
    end else if (perf_clr) begin
      perf_lu_cycles    <= '0;
      perf_long_cycles  <= '0;
      perf_pred_flushes <= '0;
    end else begin
      if (lu_busy && !long_stall && (perf_lu_cycles != '1)) begin
        perf_lu_cycles <= perf_lu_cycles + 32'd1;
      end
      if (long_stall && (perf_long_cycles != '1)) begin
        perf_long_cycles <= perf_long_cycles + 32'd1;
      end
      if (pred_eff && (perf_pred_flushes != '1)) begin
        perf_pred_flushes <= perf_pred_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT 1..3) share all inputs.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       perf_clr;
  logic [3:0] long_stall_req;
  logic       loadE, flush_pred_failedM, flush_exceptionM;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       reg_write_enE, reg_write_enM, reg_write_enW;
  logic [4:0] reg_writeE, reg_writeM, reg_writeW;

  logic [2:0] stall_f, stall_d, stall_e, stall_m, stall_w;
  logic [2:0] flush_f, flush_d, flush_e, flush_m, flush_w;
  logic [2:0] lub;
  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic [31:0] p_lu [3];
  logic [31:0] p_long [3];
  logic [31:0] p_pred [3];

  int n_vec;
  int n_err;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.REG_W(5), .LOAD_LAT(g + 1), .N_STALL(4)) u_dut (
      .clk                (clk),
      .rst                (rst),
`ifdef HAZARD_PERF_CNT_EN
      .perf_clr           (perf_clr),
      .perf_lu_cycles     (p_lu[g]),
      .perf_long_cycles   (p_long[g]),
      .perf_pred_flushes  (p_pred[g]),
`endif
      .long_stall_req     (long_stall_req),
      .loadE              (loadE),
      .flush_pred_failedM (flush_pred_failedM),
      .flush_exceptionM   (flush_exceptionM),
      .rsD                (rsD),
      .rtD                (rtD),
      .rsE                (rsE),
      .rtE                (rtE),
      .reg_write_enE      (reg_write_enE),
      .reg_write_enM      (reg_write_enM),
      .reg_write_enW      (reg_write_enW),
      .reg_writeE         (reg_writeE),
      .reg_writeM         (reg_writeM),
      .reg_writeW         (reg_writeW),
      .stallF             (stall_f[g]),
      .stallD             (stall_d[g]),
      .stallE             (stall_e[g]),
      .stallM             (stall_m[g]),
      .stallW             (stall_w[g]),
      .flushF             (flush_f[g]),
      .flushD             (flush_d[g]),
      .flushE             (flush_e[g]),
      .flushM             (flush_m[g]),
      .flushW             (flush_w[g]),
      .forward_aE         (fa[g]),
      .forward_bE         (fb[g]),
      .lu_busy            (lub[g])
    );
  end

`ifndef HAZARD_PERF_CNT_EN
  initial begin
    for (int g = 0; g < 3; g++) begin
      p_lu[g] = '0; p_long[g] = '0; p_pred[g] = '0;
    end
  end
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] lsr;
    logic       ld, pred, exc;
    logic [4:0] rsd, rtd, rse, rte;
    logic       ene, enm, enw;
    logic [4:0] we, wm, ww;
    logic [4:0] st, fl;
    logic [1:0] xa, xb;
    logic       xlub;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [3:0] lsr, input logic ld, input logic pred, input logic exc,
                              input logic [4:0] rsd, input logic [4:0] rtd, input logic [4:0] rse,
                              input logic [4:0] rte, input logic ene, input logic enm, input logic enw,
                              input logic [4:0] we, input logic [4:0] wm, input logic [4:0] ww,
                              input logic [4:0] st, input logic [4:0] fl, input logic [1:0] xa,
                              input logic [1:0] xb, input logic xlub);
    vec_t v;
    v.lsr = lsr; v.ld = ld; v.pred = pred; v.exc = exc;
    v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.ene = ene; v.enm = enm; v.enw = enw;
    v.we = we; v.wm = wm; v.ww = ww;
    v.st = st; v.fl = fl; v.xa = xa; v.xb = xb; v.xlub = xlub;
    return v;
  endfunction

  // {stallF..W, flushF..W, forward_aE, forward_bE, lu_busy}
  function automatic logic [14:0] outs(input int g);
    return {stall_f[g], stall_d[g], stall_e[g], stall_m[g], stall_w[g],
            flush_f[g], flush_d[g], flush_e[g], flush_m[g], flush_w[g],
            fa[g], fb[g], lub[g]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    long_stall_req = '0; loadE = 0; flush_pred_failedM = 0; flush_exceptionM = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    reg_write_enE = 0; reg_write_enM = 0; reg_write_enW = 0;
    reg_writeE = 0; reg_writeM = 0; reg_writeW = 0; perf_clr = 0;
  endtask

  task automatic apply(input vec_t v);
    long_stall_req = v.lsr; loadE = v.ld; flush_pred_failedM = v.pred; flush_exceptionM = v.exc;
    rsD = v.rsd; rtD = v.rtd; rsE = v.rse; rtE = v.rte;
    reg_write_enE = v.ene; reg_write_enM = v.enm; reg_write_enW = v.enw;
    reg_writeE = v.we; reg_writeM = v.wm; reg_writeW = v.ww;
  endtask

  task automatic detect_on(input logic [4:0] r);
    loadE = 1; reg_write_enE = 1; reg_writeE = r; rsD = r;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  logic [2:0] lexp2 [7];
  logic [2:0] lexp3 [7];

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rst = 1'b0;
    #2;
    for (int g = 0; g < 3; g++) chk($sformatf("reset_outs_lat%0d", g + 1), 32'(outs(g)), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // combinational vectors (lsr ld pred exc | rsD rtD rsE rtE | enE enM enW | wE wM wW | st fl fa fb lub)
    vt[0]  = mk(4'h0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  5'b00000, 5'b00000, 2'b00, 2'b00, 0);
    vt[1]  = mk(4'h0, 0, 0, 0,  0, 0, 8, 8,  0, 1, 1,  0, 8, 8,  5'b00000, 5'b00000, 2'b01, 2'b01, 0);
    vt[2]  = mk(4'h0, 0, 0, 0,  0, 0, 8, 8,  0, 0, 1,  0, 8, 8,  5'b00000, 5'b00000, 2'b10, 2'b10, 0);
    vt[3]  = mk(4'h0, 0, 0, 0,  0, 0, 0, 8,  0, 1, 1,  0, 8, 8,  5'b00000, 5'b00000, 2'b00, 2'b01, 0);
    vt[4]  = mk(4'h0, 0, 0, 0,  0, 0, 3, 4,  0, 1, 1,  0, 3, 4,  5'b00000, 5'b00000, 2'b01, 2'b10, 0);
    vt[5]  = mk(4'h0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 1,  0, 0, 0,  5'b00000, 5'b00000, 2'b00, 2'b00, 0);
    vt[6]  = mk(4'h0, 1, 0, 0,  2, 7, 0, 0,  1, 0, 0,  7, 0, 0,  5'b11000, 5'b00100, 2'b00, 2'b00, 1);
    vt[7]  = mk(4'h0, 1, 0, 0,  0, 7, 0, 0,  0, 0, 0,  7, 0, 0,  5'b00000, 5'b00000, 2'b00, 2'b00, 0);
    vt[8]  = mk(4'h0, 0, 0, 0,  0, 7, 0, 0,  1, 0, 0,  7, 0, 0,  5'b00000, 5'b00000, 2'b00, 2'b00, 0);
    vt[9]  = mk(4'h0, 1, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0, 0,  5'b00000, 5'b00000, 2'b00, 2'b00, 0);
    vt[10] = mk(4'h8, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  5'b11111, 5'b00000, 2'b00, 2'b00, 0);
    vt[11] = mk(4'h1, 1, 0, 0,  2, 7, 0, 0,  1, 0, 0,  7, 0, 0,  5'b11111, 5'b00000, 2'b00, 2'b00, 1);
    vt[12] = mk(4'h0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  5'b00000, 5'b01110, 2'b00, 2'b00, 0);
    vt[13] = mk(4'h0, 1, 0, 1,  5, 0, 0, 0,  1, 0, 0,  5, 0, 0,  5'b00000, 5'b01110, 2'b00, 2'b00, 0);
    vt[14] = mk(4'h0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  5'b00000, 5'b00100, 2'b00, 2'b00, 0);
    vt[15] = mk(4'h2, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  5'b11111, 5'b00000, 2'b00, 2'b00, 0);
    vt[16] = mk(4'h4, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  5'b11111, 5'b01110, 2'b00, 2'b00, 0);
    vt[17] = mk(4'h0, 1, 1, 0,  6, 0, 0, 0,  1, 0, 0,  6, 0, 0,  5'b00000, 5'b00100, 2'b00, 2'b00, 0);
    vt[18] = mk(4'h0, 1, 0, 0,  9, 0, 9, 0,  1, 1, 0,  9, 9, 0,  5'b11000, 5'b00100, 2'b01, 2'b00, 1);

    // Each vector lives between two clock edges and is cleared by an async reset pulse.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      apply(vt[i]);
      #3;
      for (int g = 0; g < 3; g++)
        chk($sformatf("vec%0d_lat%0d", i, g + 1), 32'(outs(g)),
            32'({vt[i].st, vt[i].fl, vt[i].xa, vt[i].xb, vt[i].xlub}));
      idle();
      rst = 1'b0; #1; rst = 1'b1;
    end

    // Load-use window length per LOAD_LAT: {stallF, stallD, flushE, lu_busy}
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      idle();
      if (k == 0) detect_on(5'd5);
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        chk($sformatf("lu_win_lat%0d_c%0d", g + 1, k), 32'({stall_f[g], stall_d[g], flush_e[g], lub[g]}),
            (k < g + 1) ? 32'hF : 32'h0);
    end

    // Long stall inside the window: {stallF, stallE, flushE}
    lexp2 = '{3'b101, 3'b110, 3'b110, 3'b110, 3'b101, 3'b000, 3'b000};
    lexp3 = '{3'b101, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b000};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      idle();
      if (k == 0) detect_on(5'd5);
      if (k >= 1 && k <= 3) long_stall_req = 4'b0100;
      @(negedge clk);
      chk($sformatf("lu_long_lat2_c%0d", k), 32'({stall_f[1], stall_e[1], flush_e[1]}), 32'(lexp2[k]));
      chk($sformatf("lu_long_lat3_c%0d", k), 32'({stall_f[2], stall_e[2], flush_e[2]}), 32'(lexp3[k]));
    end

    // Mispredict pulse under long stall: {stallE, flushE}
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      idle();
      if (k == 0) flush_pred_failedM = 1;
      if (k <= 2) long_stall_req = 4'b0001;
      @(negedge clk);
      chk($sformatf("pend_c%0d", k), 32'({stall_e[0], flush_e[0]}),
          (k <= 2) ? 32'h2 : ((k == 3) ? 32'h1 : 32'h0));
    end

    // Exception under long stall discards a parked mispredict: {flushD, flushE}
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      idle();
      if (k == 0) begin flush_pred_failedM = 1; long_stall_req = 4'b1000; end
      if (k == 1) begin flush_exceptionM = 1; long_stall_req = 4'b1000; end
      @(negedge clk);
      chk($sformatf("pend_exc_c%0d", k), 32'({flush_d[1], flush_e[1]}), (k == 1) ? 32'h3 : 32'h0);
    end

    // Detect coinciding with exception: {stallF, stallD, flushD, flushE, flushM, lu_busy}
    do_reset();
    @(posedge clk); #1;
    idle(); detect_on(5'd5); flush_exceptionM = 1;
    @(negedge clk);
    chk("simul_exc_t", 32'({stall_f[2], stall_d[2], flush_d[2], flush_e[2], flush_m[2], lub[2]}), 32'b001110);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("simul_exc_t1_busy", 32'(lub[2]), 32'h0);

    // Exception mid-window clears the counter
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      idle();
      if (k == 0) detect_on(5'd5);
      if (k == 1) flush_exceptionM = 1;
      @(negedge clk);
      chk($sformatf("exc_mid_c%0d", k), 32'({lub[2], flush_e[2]}), (k == 0) ? 32'h3 : ((k == 1) ? 32'h1 : 32'h0));
    end

    // Async reset mid-window drops lu_busy without a clock edge
    do_reset();
    @(posedge clk); #1;
    idle(); detect_on(5'd5);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("rst_mid_before", 32'({lub[2], stall_f[2]}), 32'h3);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_after", 32'({lub[2], stall_f[2]}), 32'h0);
    #1 rst = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    for (int g = 0; g < 3; g++)
      chk($sformatf("perf_rst_lat%0d", g + 1), p_lu[g] | p_long[g] | p_pred[g], 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      idle();
      if (k == 0) detect_on(5'd5);
      if (k >= 3 && k <= 6) long_stall_req = 4'b0010;
      if (k == 7) flush_pred_failedM = 1;
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("perf_lu_lat%0d", g + 1), p_lu[g], 32'(g + 1));
      chk($sformatf("perf_long_lat%0d", g + 1), p_long[g], 32'd4);
      chk($sformatf("perf_pred_lat%0d", g + 1), p_pred[g], 32'd1);
    end
    @(posedge clk); #1;
    idle(); perf_clr = 1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("perf_clr_lat%0d", g + 1), p_lu[g] | p_long[g] | p_pred[g], 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core: forwarding selects, multi-cycle load-use interlock, global stall merge, and flush generation. It is the parametrised successor of the single-bubble hazard unit. It adds a configurable load-use latency counter, an N-source long-stall vector, and a pending-flush latch so that branch mispredicts arriving under a global stall are never lost. It sits beside the datapath and drives every pipeline register's stall/flush pins.

## Interface
Parameters:
- REG_W, 5, register-address width
- LOAD_LAT, 1, load-use bubble cycles (legal 1..4)
- N_STALL, 4, number of long-stall request sources (i-cache, d-cache, div, mult, ...)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- long_stall_req  in  N_STALL  global stall requests; OR-merged
- loadE  in  1  E-stage instruction is a load
- flush_pred_failedM  in  1  mispredict resolved in M; may be a 1-cycle pulse
- flush_exceptionM  in  1  exception taken in M
- rsD, rtD, rsE, rtE  in  REG_W  source registers
- reg_write_enE/M/W  in  1  stage writes the register file
- reg_writeE/M/W  in  REG_W  destination registers
- stallF, stallD, stallE, stallM, stallW  out  1  stage hold
- flushF, flushD, flushE, flushM, flushW  out  1  stage clear
- forward_aE, forward_bE  out  2  00 regfile, 01 from M, 10 from W
- lu_busy  out  1  load-use interlock active (detect or counter nonzero)

## Operation
- Forwarding (combinational): src≠0 & reg_write_enM & src==reg_writeM → 01; else same test on W → 10; else 00. M has priority over W.
- long = |long_stall_req.
- flush_any = flush_exceptionM | pred_eff.
- detect = loadE & reg_write_enE & ((rsD≠0 & rsD==reg_writeE) | (rtD≠0 & rtD==reg_writeE)) & ~flush_any.
- lu_cnt (width clog2(LOAD_LAT+1)):
  - Loads LOAD_LAT-1 on detect & ~long & lu_cnt==0.
  - Decrements when nonzero & ~long; holds under long.
  - Clears to 0 on flush_any.
- lu_busy = detect | (lu_cnt≠0 & ~flush_any).
- pend (pending mispredict):
  - Sets on flush_pred_failedM & long & ~flush_exceptionM.
  - Clears on ~long or flush_exceptionM.
  - pred_eff = (flush_pred_failedM | pend) & ~long.
- stallF = stallD = long | lu_busy; stallE = stallM = stallW = long.
- flushD = flushM = flush_exceptionM.
- flushE = flush_exceptionM | pred_eff | (lu_busy & ~long).
- flushF = flushW = 0.
- Exception dominates: clears pend and lu_cnt in the same edge.

## Timing
- Forward selects, stalls, and flushes are combinational from inputs plus state; zero-cycle latency.
- Reset (rst=0): lu_cnt=0, pend=0 immediately. Outputs then depend only on inputs (no residual bubble, no pending flush).
- Load-use with detect at cycle t and no long stall:
  - stallF/D and flushE are asserted for exactly LOAD_LAT cycles (t..t+LOAD_LAT-1).
  - D issues at t+LOAD_LAT.
- A long stall during a load-use window extends it cycle-for-cycle; flushE is masked while long=1.
- A mispredict pulse under long stall produces flushE on the first cycle with long=0, exactly once.
- Simultaneous detect and flush: flush wins; no bubble, counter stays 0.
- LOAD_LAT=1: lu_cnt is constantly 0; behaviour equals the single-bubble interlock.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs perf_lu_cycles, perf_long_cycles, perf_pred_flushes (32 bits each) and input perf_clr (1 bit).
  - perf_lu_cycles increments on lu_busy & ~long.
  - perf_long_cycles increments on long.
  - perf_pred_flushes increments on pred_eff.
  - Counters saturate at 2^32-1; perf_clr zeroes synchronously; reset value 0.
- HAZARD_PERF_CNT_EN undefined: those ports and registers do not exist; all other behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - the fwd_sel_t typedef
  - a LU_CNT_W(LOAD_LAT) width function
- One sub-module, hazard_fwd_sel: per-operand M/W priority compare. Instantiated twice (a and b operands).
- Counter, pend latch, and optional perf counters live in hazard_ctrl.

## Test plan
- Forwarding: rsE=rtE=8, reg_writeM=reg_writeW=8, both enables 1 → forward_aE=forward_bE=01. Drop M enable → 10. rsE=0 with matches → 00.
- Load-use, LOAD_LAT=3: loadE=1, reg_writeE=5, rsD=5 at t → stallF/D and flushE high at t,t+1,t+2; low at t+3; lu_busy likewise.
- Long stall inside window, LOAD_LAT=2: detect at t, long_stall_req=4'b0100 for t+1..t+3 → flushE low t+1..t+3, high t+4; stallE/M/W high t+1..t+3.
- Pending flush: 1-cycle flush_pred_failedM at t with long=1 through t+2 → flushE=0 t..t+2, flushE=1 at t+3 only, pend=0 after.
- Simultaneous events: detect and flush_exceptionM at t → flushD/E/M=1, stallF/D=0, lu_cnt=0 at t+1. rst pulled low mid-window → lu_busy drops without a clock edge.
- With HAZARD_PERF_CNT_EN: 3 load-use cycles, 4 long cycles, 1 mispredict → counters read 3/4/1; perf_clr → all 0 next cycle.
